risc_ctrl_fsm: RTL and testbench

Parametrised instruction-sequencing controller for the RISC core. It is the next generation of the fixed four-phase program FSM. It adds handshaked instruction fetch, variable-latency execute, an optional memory phase, stall, halt, interrupt entry and a retired-instruction counter. It sits between the core's memory/ALU datapath and the register file, and drives the per-phase enable strobes.

---
 rtl/risc_ctrl_fsm.sv | 104 ++++++++++
 tb/tb_risc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: instruction-sequencing controller with handshaked fetch, variable execute, memory phase, stall, halt and irq
module risc_ctrl_fsm #(
    parameter int EXEC_CNT_W   = 4,
    parameter int RESET_CYCLES = 2,
    parameter int IRQ_EN       = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  fetch_ready,
    input  logic [EXEC_CNT_W-1:0] exec_cycles,
    input  logic                  mem_op,
    input  logic                  mem_ready,
    input  logic                  halt_req,
    input  logic                  irq,
    output logic [2:0]            current_state,
    output logic                  fetch_en,
    output logic                  ops_en,
    output logic                  exec_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic                  irq_ack,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_count
);
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_OPS   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;
    localparam logic [2:0] S_IRQ   = 3'd7;
    localparam logic [3:0] RST_INIT = 4'(RESET_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [EXEC_CNT_W-1:0] exec_q, exec_d;
    logic [3:0]            rst_cnt_q, rst_cnt_d;
    logic                  mem_op_q, mem_op_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        exec_d    = exec_q;
        rst_cnt_d = rst_cnt_q;
        mem_op_d  = mem_op_q;
        cnt_d     = cnt_q;
        if (!stall) begin
            case (state_q)
                S_RESET: begin
                    state_d   = (rst_cnt_q == 4'd0) ? S_FETCH : S_RESET;
                    rst_cnt_d = (rst_cnt_q == 4'd0) ? rst_cnt_q : rst_cnt_q - 4'd1;
                end
                S_FETCH: state_d = fetch_ready ? S_OPS : S_FETCH;
                S_OPS: begin
                    // zero latency still spends one cycle in EXECUTE
                    exec_d   = (exec_cycles == '0) ? EXEC_CNT_W'(1) : exec_cycles;
                    mem_op_d = mem_op;
                    state_d  = S_EXEC;
                end
                S_EXEC: begin
                    exec_d = exec_q - 1'b1;
                    if (exec_q == EXEC_CNT_W'(1))
                        state_d = mem_op_q ? S_MEM : S_WB;
                end
                S_MEM: state_d = mem_ready ? S_WB : S_MEM;
                S_WB: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (IRQ_EN != 0 && irq) ? S_IRQ : halt_req ? S_HALT : S_FETCH;
                end
                S_IRQ:   state_d = S_FETCH;
                S_HALT:  state_d = halt_req ? S_HALT : S_FETCH;
                default: state_d = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_RESET;
            exec_q    <= '0;
            rst_cnt_q <= RST_INIT;
            mem_op_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            exec_q    <= exec_d;
            rst_cnt_q <= rst_cnt_d;
            mem_op_q  <= mem_op_d;
            cnt_q     <= cnt_d;
        end
    end

    assign current_state = state_q;
    assign instr_count   = cnt_q;
    assign fetch_en      = (state_q == S_FETCH) && !stall;
    assign ops_en        = (state_q == S_OPS) && !stall;
    assign exec_en       = (state_q == S_EXEC) && !stall;
    assign mem_en        = (state_q == S_MEM) && !stall;
    assign wb_en         = (state_q == S_WB) && !stall;
    assign irq_ack       = (state_q == S_IRQ) && !stall;
    assign halted        = (state_q == S_HALT);
endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// tb_risc_ctrl_fsm: directed bench for risc_ctrl_fsm with default, IRQ-disabled and 4-bit-counter instances
module tb_risc_ctrl_fsm;
    logic       clk = 0, reset = 0, stall = 0, fetch_ready = 0, mem_op = 0, mem_ready = 0, halt_req = 0, irq = 0;
    logic [3:0] exec_cycles = 0;
    logic [2:0] st_a, st_b, st_c;
    logic       fe_a, oe_a, ee_a, me_a, we_a, ack_a, hlt_a;
    logic       fe_b, oe_b, ee_b, me_b, we_b, ack_b, hlt_b;
    logic       fe_c, oe_c, ee_c, me_c, we_c, ack_c, hlt_c;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    risc_ctrl_fsm dut_a (.clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .exec_cycles(exec_cycles), .mem_op(mem_op), .mem_ready(mem_ready), .halt_req(halt_req), .irq(irq),
        .current_state(st_a), .fetch_en(fe_a), .ops_en(oe_a), .exec_en(ee_a), .mem_en(me_a), .wb_en(we_a),
        .irq_ack(ack_a), .halted(hlt_a), .instr_count(cnt_a));
    risc_ctrl_fsm #(.IRQ_EN(0)) dut_b (.clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .exec_cycles(exec_cycles), .mem_op(mem_op), .mem_ready(mem_ready), .halt_req(halt_req), .irq(irq),
        .current_state(st_b), .fetch_en(fe_b), .ops_en(oe_b), .exec_en(ee_b), .mem_en(me_b), .wb_en(we_b),
        .irq_ack(ack_b), .halted(hlt_b), .instr_count(cnt_b));
    risc_ctrl_fsm #(.CNT_W(4)) dut_c (.clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .exec_cycles(exec_cycles), .mem_op(mem_op), .mem_ready(mem_ready), .halt_req(halt_req), .irq(irq),
        .current_state(st_c), .fetch_en(fe_c), .ops_en(oe_c), .exec_en(ee_c), .mem_en(me_c), .wb_en(we_c),
        .irq_ack(ack_c), .halted(hlt_c), .instr_count(cnt_c));

    function automatic logic [4:0] strobes_for(input logic [2:0] s, input logic stl);
        return stl ? 5'b0 : {s == 3'd1, s == 3'd2, s == 3'd3, s == 3'd4, s == 3'd5};
    endfunction

    task automatic test_reset();
        #2 reset = 1;
        #1;
        vectors++;
        if ({st_a, cnt_a, fe_a, oe_a, ee_a, me_a, we_a, ack_a, hlt_a} !== 28'd0) begin
            miscompares++;
            $display("FAIL reset_values: state=%0d count=%0d strobes=%b want all zero", st_a, cnt_a,
                     {fe_a, oe_a, ee_a, me_a, we_a, ack_a, hlt_a});
        end
        vectors++;
        if (st_b !== 3'd0 || st_c !== 3'd0 || cnt_c !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_other: st_b=%0d st_c=%0d cnt_c=%0d want 0", st_b, st_c, cnt_c);
        end
        @(negedge clk);
        reset = 0;
        fetch_ready = 1;
        @(negedge clk);
        vectors++;
        if (st_a !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_hold: state=%0d want 0", st_a);
        end
        @(negedge clk);
        vectors++;
        if (st_a !== 3'd1 || fe_a !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_to_fetch: state=%0d fetch_en=%0d want 1 1", st_a, fe_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        for (int i = 0; i < 12; i++) begin
            e = (i % 4 == 3) ? 3'd5 : 3'(i % 4 + 1);
            vectors++;
            if (st_a !== e || {fe_a, oe_a, ee_a, me_a, we_a} !== strobes_for(e, 1'b0)) begin
                miscompares++;
                $display("FAIL b2b_seq[%0d]: state=%0d strobes=%b want %0d %b", i, st_a,
                         {fe_a, oe_a, ee_a, me_a, we_a}, e, strobes_for(e, 1'b0));
            end
            @(negedge clk);
        end
        vectors++;
        if (st_a !== 3'd1 || cnt_a !== 16'd3) begin
            miscompares++;
            $display("FAIL b2b_count: state=%0d count=%0d want 1 3", st_a, cnt_a);
        end
    endtask

    task automatic test_mem_latency();
        int n = 0, ex = 0, mc = 0;
        logic [2:0] prev = 0;
        exec_cycles = 5;
        mem_op = 1;
        mem_ready = 0;
        while (n < 40 && !(n > 0 && st_a == 3'd1)) begin
            ex += int'(ee_a);
            if (me_a) begin
                mc++;
                if (mc == 3) mem_ready = 1;
            end
            prev = st_a;
            n++;
            @(negedge clk);
        end
        mem_ready = 0;
        mem_op = 0;
        vectors++;
        if (n != 11 || ex != 5 || mc != 3) begin
            miscompares++;
            $display("FAIL mem_latency: cycles=%0d exec=%0d mem=%0d want 11 5 3", n, ex, mc);
        end
        vectors++;
        if (prev !== 3'd5 || cnt_a !== 16'd4) begin
            miscompares++;
            $display("FAIL mem_wb: last=%0d count=%0d want 5 4", prev, cnt_a);
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp [9];
        logic [15:0] c0;
        exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd1};
        c0 = cnt_a;
        exec_cycles = 3;
        for (int n = 0; n < 9; n++) begin
            stall = (n == 3 || n == 4);
            #1;
            vectors++;
            if (st_a !== exp[n] || {fe_a, oe_a, ee_a, me_a, we_a} !== strobes_for(exp[n], stall)) begin
                miscompares++;
                $display("FAIL stall_seq[%0d]: state=%0d strobes=%b want %0d %b", n, st_a,
                         {fe_a, oe_a, ee_a, me_a, we_a}, exp[n], strobes_for(exp[n], stall));
            end
            if (stall) begin
                vectors++;
                if (cnt_a !== c0) begin
                    miscompares++;
                    $display("FAIL stall_count[%0d]: count=%0d want %0d", n, cnt_a, c0);
                end
            end
            if (n < 8) @(negedge clk);
        end
        stall = 0;
        vectors++;
        if (cnt_a !== c0 + 16'd1) begin
            miscompares++;
            $display("FAIL stall_done: count=%0d want %0d", cnt_a, c0 + 16'd1);
        end
    endtask

    task automatic test_irq_halt();
        logic [2:0] ea [12];
        logic [2:0] eb [12];
        ea = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd6, 3'd1};
        eb = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd1};
        exec_cycles = 0;
        for (int n = 0; n < 12; n++) begin
            irq = (n == 3);
            halt_req = (n >= 3 && n < 10);
            #1;
            vectors++;
            if (st_a !== ea[n] || ack_a !== (n == 4) || hlt_a !== (ea[n] == 3'd6)) begin
                miscompares++;
                $display("FAIL irq_a[%0d]: state=%0d ack=%0d halted=%0d want %0d %0d %0d", n, st_a, ack_a,
                         hlt_a, ea[n], n == 4, ea[n] == 3'd6);
            end
            vectors++;
            if (st_b !== eb[n] || ack_b !== 1'b0 || hlt_b !== (eb[n] == 3'd6)) begin
                miscompares++;
                $display("FAIL irq_off[%0d]: state=%0d ack=%0d halted=%0d want %0d 0 %0d", n, st_b, ack_b,
                         hlt_b, eb[n], eb[n] == 3'd6);
            end
            if (n < 11) @(negedge clk);
        end
        irq = 0;
        halt_req = 0;
        vectors++;
        if (cnt_a !== 16'd7 || cnt_b !== 16'd6) begin
            miscompares++;
            $display("FAIL irq_counts: a=%0d b=%0d want 7 6", cnt_a, cnt_b);
        end
    endtask

    task automatic test_wrap_reset();
        int n = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (st_c !== 3'd1 || cnt_c !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_start: state=%0d count=%0d want 1 0", st_c, cnt_c);
        end
        repeat (68) @(negedge clk);
        vectors++;
        if (st_c !== 3'd1 || cnt_c !== 4'd1 || cnt_a !== 16'd17) begin
            miscompares++;
            $display("FAIL wrap_count: state=%0d cnt_c=%0d cnt_a=%0d want 1 1 17", st_c, cnt_c, cnt_a);
        end
        mem_op = 1;
        mem_ready = 0;
        while (st_c != 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (st_c !== 3'd4 || n != 3) begin
            miscompares++;
            $display("FAIL reach_mem: state=%0d cycles=%0d want 4 3", st_c, n);
        end
        #2 reset = 1;
        #1;
        vectors++;
        if (st_c !== 3'd0 || cnt_c !== 4'd0 || me_c !== 1'b0 || st_a !== 3'd0 || cnt_a !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset: st_c=%0d cnt_c=%0d mem_en=%0d st_a=%0d cnt_a=%0d want 0 0 0 0 0",
                     st_c, cnt_c, me_c, st_a, cnt_a);
        end
        @(negedge clk);
        reset = 0;
        mem_op = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_mem_latency();
        test_stall();
        test_irq_halt();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
